// File: rtl/logic_pipe_pkg.sv
// logic_pipe shared definitions: op codes and the bitwise function.
// Optional parity output is enabled by LOGIC_PIPE_PARITY_EN.
package logic_pipe_pkg;

  localparam int OPW  = 3;
  localparam int MAXW = 64;

  localparam logic [OPW-1:0] OP_AND   = 3'd0;
  localparam logic [OPW-1:0] OP_OR    = 3'd1;
  localparam logic [OPW-1:0] OP_XOR   = 3'd2;
  localparam logic [OPW-1:0] OP_NAND  = 3'd3;
  localparam logic [OPW-1:0] OP_NOR   = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR  = 3'd5;
  localparam logic [OPW-1:0] OP_ANDN  = 3'd6;
  localparam logic [OPW-1:0] OP_PASSA = 3'd7;

  // Callers zero-extend operands to MAXW and cast the result back down.
  function automatic logic [MAXW-1:0] logic_op(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input logic [OPW-1:0]  op
  );
    logic [MAXW-1:0] r;
    r = a;
    unique case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      OP_PASSA: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_if.sv
// logic_pipe handshake bundle: operand side and result side.
// Port p exists only when LOGIC_PIPE_PARITY_EN is defined.
interface logic_pipe_if #(
  parameter int WIDTH = 8
);
  import logic_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             d;
`ifdef LOGIC_PIPE_PARITY_EN
  logic             p;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, d, p
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, d, p
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, d
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, d
  );
`endif

endinterface

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one valid bit plus payload register.
// Payload only changes when a valid item lands, so it holds under bubbles.
module logic_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          vld,
  output logic [DW-1:0] data
);

  // Load from upstream when allowed; keep old payload on an empty load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld <= in_vld;
      if (in_vld) data <= in_data;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: bitwise op + zero flag, carried through STAGES stages.
// Define LOGIC_PIPE_PARITY_EN to add parity output p.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  logic_pipe_if.slave bus
);

`ifdef LOGIC_PIPE_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] res;
  logic [PW-1:0]    pay;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   ld;
  logic [PW-1:0]     sd [STAGES];

  assign res = WIDTH'(logic_op(MAXW'(bus.a), MAXW'(bus.b), bus.op));

`ifdef LOGIC_PIPE_PARITY_EN
  assign pay = {^res, ~|res, res};
`else
  assign pay = {~|res, res};
`endif

  // Ready chain: a stage loads if empty or if the next stage can load.
  always_comb begin
    ld = '0;
    ld[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld[k] || ld[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_head
      logic_pipe_stage #(.DW(PW)) u_stg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld[k]),
        .in_vld  (bus.in_valid),
        .in_data (pay),
        .vld     (vld[k]),
        .data    (sd[k])
      );
    end else begin : g_body
      logic_pipe_stage #(.DW(PW)) u_stg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld[k]),
        .in_vld  (vld[k-1]),
        .in_data (sd[k-1]),
        .vld     (vld[k]),
        .data    (sd[k])
      );
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.c         = sd[STAGES-1][WIDTH-1:0];
  assign bus.d         = sd[STAGES-1][WIDTH];
`ifdef LOGIC_PIPE_PARITY_EN
  assign bus.p         = sd[STAGES-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: directed checks on 2- and 4-stage pipes,
// plus random streams over several WIDTH/STAGES shapes.
module tb_logic_pipe;

  localparam int NRND = 1000;

  logic clk;
  logic rst2, rst4, rst_r;
  int   n_cmp, n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-bit truth table {a,b} -> result, one nibble per op code.
  function automatic logic [3:0] ttab(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0100;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a,
    input logic [31:0] b, input logic [2:0] op, input int w);
    logic [31:0] r;
    logic [3:0]  t;
    r = '0;
    t = ttab(op);
    for (int i = 0; i < w; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  logic_pipe_if #(.WIDTH(8)) if2();
  logic_pipe_if #(.WIDTH(8)) if4();

  logic_pipe #(.WIDTH(8), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst2), .bus(if2)
  );
  logic_pipe #(.WIDTH(8), .STAGES(4)) u4 (
    .clk(clk), .rst_n(rst4), .bus(if4)
  );

  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int W = (g / 2 == 0) ? 1 : (g / 2 == 1) ? 8 : 32;
    localparam int S = (g % 2 == 0) ? 1 : 3;
    localparam logic [31:0] MSK =
      (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

    logic_pipe_if #(.WIDTH(W)) ifc();
    logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_r), .bus(ifc)
    );

    logic [31:0] q_c [$];
    logic        done;

    initial begin : run
      int sent, got, cyc;
      logic [31:0] ra, rb, seen_c, ec;
      logic [2:0]  ro;
      logic        seen_d;
      done = 1'b0;
      sent = 0; got = 0; cyc = 0;
      seen_c = '0; seen_d = 1'b0;
      ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
      ifc.a = '0; ifc.b = '0; ifc.op = '0;
      wait (rst_r === 1'b1);
      while ((sent < NRND || q_c.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        ra = $urandom & MSK;
        rb = $urandom & MSK;
        ro = 3'($urandom_range(0, 7));
        ifc.a = ra[W-1:0];
        ifc.b = rb[W-1:0];
        ifc.op = ro;
        ifc.in_valid = (sent < NRND) && ($urandom_range(0, 3) != 0);
        ifc.out_ready = (sent >= NRND) || ($urandom_range(0, 1) == 1);
        #1;
        chk($sformatf("r%0d_rdy", g), 32'(ifc.in_ready),
            32'((q_c.size() < S) || ifc.out_ready));
        if (ifc.out_valid) begin
          if (q_c.size() == 0) begin
            chk($sformatf("r%0d_spurious", g), 0, 1);
          end else begin
            chk($sformatf("r%0d_c", g), 32'(ifc.c), q_c[0]);
            chk($sformatf("r%0d_d", g), 32'(ifc.d), 32'(q_c[0] == 0));
`ifdef LOGIC_PIPE_PARITY_EN
            chk($sformatf("r%0d_p", g), 32'(ifc.p), 32'(^q_c[0]));
`endif
            if (ifc.out_ready) begin
              void'(q_c.pop_front());
              got++;
            end
          end
          seen_c = 32'(ifc.c);
          seen_d = ifc.d;
        end else begin
          chk($sformatf("r%0d_hold_c", g), 32'(ifc.c), seen_c);
          chk($sformatf("r%0d_hold_d", g), 32'(ifc.d), 32'(seen_d));
        end
        if (ifc.in_valid && ifc.in_ready) begin
          ec = ref_op(ra, rb, ro, W);
          q_c.push_back(ec);
          sent++;
        end
      end
      chk($sformatf("r%0d_nin", g), sent, NRND);
      chk($sformatf("r%0d_nout", g), got, sent);
      ifc.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  logic [7:0] sw_c [9];

  initial begin
    n_cmp = 0; n_bad = 0;
    sw_c = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0,
             8'h00};
    rst2 = 1'b0; rst4 = 1'b0; rst_r = 1'b0;
    if2.in_valid = 1'b0; if2.out_ready = 1'b0;
    if2.a = '0; if2.b = '0; if2.op = '0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0;
    if4.a = '0; if4.b = '0; if4.op = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b1; rst4 = 1'b1; rst_r = 1'b1;
    #1;
    chk("rst_ov", 32'(if2.out_valid), 0);
    chk("rst_c", 32'(if2.c), 0);
    chk("rst_d", 32'(if2.d), 0);
    chk("rst_rdy", 32'(if2.in_ready), 1);
`ifdef LOGIC_PIPE_PARITY_EN
    chk("rst_p", 32'(if2.p), 0);
`endif

    // op sweep F0/3C then AA^AA, out_ready held high
    if2.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("sw%0d_v", i - 2), 32'(if2.out_valid), 1);
        chk($sformatf("sw%0d_c", i - 2), 32'(if2.c), 32'(sw_c[i-2]));
        chk($sformatf("sw%0d_d", i - 2), 32'(if2.d), 32'(i == 10));
`ifdef LOGIC_PIPE_PARITY_EN
        chk($sformatf("sw%0d_p", i - 2), 32'(if2.p), 32'(^sw_c[i-2]));
`endif
      end
      if (i < 9) begin
        if2.in_valid = 1'b1;
        if2.a = (i < 8) ? 8'hF0 : 8'hAA;
        if2.b = (i < 8) ? 8'h3C : 8'hAA;
        if2.op = (i < 8) ? 3'(i) : 3'd2;
        #1 chk($sformatf("sw%0d_rdy", i), 32'(if2.in_ready), 1);
      end else begin
        if2.in_valid = 1'b0;
      end
    end

    // stall with three items
    @(negedge clk);
    chk("st_empty", 32'(if2.out_valid), 0);
    chk("st_hold_c", 32'(if2.c), 0);
    chk("st_hold_d", 32'(if2.d), 1);
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1; if2.a = 8'hA5; if2.b = 8'h0F; if2.op = 3'd1;
    #1 chk("st_rdy1", 32'(if2.in_ready), 1);
    @(negedge clk);
    if2.a = 8'h01; if2.b = 8'h01; if2.op = 3'd0;
    #1 chk("st_rdy2", 32'(if2.in_ready), 1);
    @(negedge clk);
    if2.a = 8'hFF; if2.b = 8'h00; if2.op = 3'd4;
    #1 chk("st_rdy3", 32'(if2.in_ready), 0);
    chk("st_v1", 32'(if2.out_valid), 1);
    chk("st_c1", 32'(if2.c), 32'h0AF);
    @(negedge clk);
    #1 chk("st_rdy4", 32'(if2.in_ready), 0);
    chk("st_c1h", 32'(if2.c), 32'h0AF);
    if2.out_ready = 1'b1;
    #1 chk("st_rdy5", 32'(if2.in_ready), 1);
    @(negedge clk);
    if2.in_valid = 1'b0;
    chk("st_v2", 32'(if2.out_valid), 1);
    chk("st_c2", 32'(if2.c), 32'h001);
    chk("st_d2", 32'(if2.d), 0);
    @(negedge clk);
    chk("st_v3", 32'(if2.out_valid), 1);
    chk("st_c3", 32'(if2.c), 32'h000);
    chk("st_d3", 32'(if2.d), 1);
    @(negedge clk);
    chk("st_end", 32'(if2.out_valid), 0);

    // reset with two items in flight, stalled
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1; if2.a = 8'h3C; if2.b = 8'h0F; if2.op = 3'd1;
    @(negedge clk);
    if2.a = 8'h0F; if2.b = 8'hF0; if2.op = 3'd2;
    @(negedge clk);
    chk("mr_pre_v", 32'(if2.out_valid), 1);
    chk("mr_pre_c", 32'(if2.c), 32'h03F);
    rst2 = 1'b0;
    if2.a = 8'h12; if2.b = 8'h00; if2.op = 3'd7;
    @(negedge clk);
    rst2 = 1'b1;
    if2.in_valid = 1'b0;
    #1;
    chk("mr_v", 32'(if2.out_valid), 0);
    chk("mr_c", 32'(if2.c), 0);
    chk("mr_d", 32'(if2.d), 0);
    chk("mr_rdy", 32'(if2.in_ready), 1);
    if2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mr_gone%0d", i), 32'(if2.out_valid), 0);
    end

    // bubble collapse on the 4-stage pipe
    @(negedge clk);
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1; if4.a = 8'h5A; if4.b = 8'h00; if4.op = 3'd7;
    #1 chk("bc_rdy1", 32'(if4.in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      if4.in_valid = 1'b0;
    end
    if4.in_valid = 1'b1; if4.a = 8'hC3; if4.op = 3'd7;
    #1 chk("bc_rdy2", 32'(if4.in_ready), 1);
    @(negedge clk);
    if4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bc_v1", 32'(if4.out_valid), 1);
    chk("bc_c1", 32'(if4.c), 32'h05A);
    if4.out_ready = 1'b1;
    @(negedge clk);
    chk("bc_v2", 32'(if4.out_valid), 1);
    chk("bc_c2", 32'(if4.c), 32'h0C3);
    @(negedge clk);
    chk("bc_v3", 32'(if4.out_valid), 0);
    chk("bc_hold", 32'(if4.c), 32'h0C3);

    // wait for the random streams
    for (int t = 0; t < 30000; t++) begin
      if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
          g_rnd[3].done && g_rnd[4].done && g_rnd[5].done) break;
      @(negedge clk);
    end
    chk("rnd_finished",
        32'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
            g_rnd[3].done && g_rnd[4].done && g_rnd[5].done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
